// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin/fixed-priority mux arbiter.
package mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   // Index width for N channels; a single channel still carries a 1-bit index.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin from an internal pointer, or fixed lowest-index priority.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int MODE = MODE_RR,
   localparam int M    = sel_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt,
   output logic [M-1:0] gnt_idx
);

   logic [M-1:0] ptr_q, ptr_d;
   logic [N-1:0] mask;
   logic [N-1:0] masked_req;
   logic [N-1:0] pick;

   // Requests at or above ptr take precedence; if none, wrap to the full request set.
   always_comb begin
      mask       = '0;
      masked_req = '0;
      pick       = '0;
      gnt        = '0;
      gnt_idx    = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (MODE == MODE_RR) && (i >= int'(ptr_q));
      end
      masked_req = req & mask;
      pick       = (|masked_req) ? masked_req : req;
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = M'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (MODE == MODE_RR && advance) begin
         ptr_d = (gnt_idx == M'(N - 1)) ? '0 : gnt_idx + M'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N:1 multiplexer with internal arbitration and a single registered valid/ready output stage.
module rr_mux_arbiter
   import mux_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int W    = 8,
   parameter  int MODE = MODE_RR,
   localparam int M    = sel_width(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic [M-1:0]   out_sel,
   output logic           out_valid,
   input  logic           out_ready
);

   // Handshake: a word moves on any cycle where valid and ready are both high on that side.
   logic [W-1:0] out_data_q, out_data_d;
   logic [M-1:0] out_sel_q, out_sel_d;
   logic         out_valid_q, out_valid_d;
   logic [N-1:0] gnt;
   logic [M-1:0] gnt_idx;
   logic [W-1:0] sel_data;
   logic         load;
   logic         advance;

   rr_arbiter #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (in_valid),
      .advance (advance),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // in_ready is gated by rst_n so producers see no accept while reset is held.
   assign load     = !out_valid_q || out_ready;
   assign in_ready = {N{rst_n & load}} & gnt;
   assign advance  = |(in_valid & in_ready);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == M'(i)) begin
            sel_data = in_data[i*W +: W];
         end
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out_valid_d = advance;
         if (advance) begin
            out_data_d = sel_data;
            out_sel_d  = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter across RR/fixed modes and N = 4, 3, 1.
module tb_rr_mux_arbiter;
   import mux_pkg::*;

   typedef struct {
      int         dut;   // 0: N4 RR, 1: N4 fixed, 2: N3 RR, 3: N1 RR
      logic [3:0] iv;
      logic       ordy;
      logic [7:0] din;   // channel data for the N=1 instance only
      logic [3:0] rdy;   // expected in_ready before the edge
      logic       vld;   // expected outputs after the edge
      logic [7:0] data;
      logic [1:0] sel;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] data_a = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   logic [31:0] data_b = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
   logic [23:0] data_c = {8'hC2, 8'hC1, 8'hC0};
   logic [7:0]  data_d = 8'h00;

   logic [3:0] iv_a = '0, iv_b = '0;
   logic [2:0] iv_c = '0;
   logic [0:0] iv_d = '0;
   logic       ordy_a = 1'b1, ordy_b = 1'b1, ordy_c = 1'b1, ordy_d = 1'b1;

   logic [3:0] rdy_a, rdy_b;
   logic [2:0] rdy_c;
   logic [0:0] rdy_d;
   logic [7:0] od_a, od_b, od_c, od_d;
   logic [1:0] os_a, os_b, os_c;
   logic [0:0] os_d;
   logic       ov_a, ov_b, ov_c, ov_d;

   rr_mux_arbiter #(.N(4), .W(8), .MODE(MODE_RR)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(data_a), .in_valid(iv_a), .in_ready(rdy_a),
      .out_data(od_a), .out_sel(os_a), .out_valid(ov_a), .out_ready(ordy_a));
   rr_mux_arbiter #(.N(4), .W(8), .MODE(MODE_FIXED)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(data_b), .in_valid(iv_b), .in_ready(rdy_b),
      .out_data(od_b), .out_sel(os_b), .out_valid(ov_b), .out_ready(ordy_b));
   rr_mux_arbiter #(.N(3), .W(8), .MODE(MODE_RR)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(data_c), .in_valid(iv_c), .in_ready(rdy_c),
      .out_data(od_c), .out_sel(os_c), .out_valid(ov_c), .out_ready(ordy_c));
   rr_mux_arbiter #(.N(1), .W(8), .MODE(MODE_RR)) dut_d (
      .clk(clk), .rst_n(rst_n), .in_data(data_d), .in_valid(iv_d), .in_ready(rdy_d),
      .out_data(od_d), .out_sel(os_d), .out_valid(ov_d), .out_ready(ordy_d));

   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic add(input int dut, input logic [3:0] iv, input logic ordy, input logic [7:0] din,
                      input logic [3:0] rdy, input logic vld, input logic [7:0] data,
                      input logic [1:0] sel);
      vecs.push_back('{dut, iv, ordy, din, rdy, vld, data, sel});
   endtask

   function automatic logic [3:0] obs_rdy(input int dut);
      case (dut)
         0:       return rdy_a;
         1:       return rdy_b;
         2:       return {1'b0, rdy_c};
         default: return {3'b000, rdy_d};
      endcase
   endfunction

   function automatic logic [10:0] obs_out(input int dut);
      case (dut)
         0:       return {ov_a, od_a, os_a};
         1:       return {ov_b, od_b, os_b};
         2:       return {ov_c, od_c, os_c};
         default: return {ov_d, od_d, 1'b0, os_d};
      endcase
   endfunction

   task automatic apply(input vec_t v, input int k);
      @(negedge clk);
      iv_a = '0; iv_b = '0; iv_c = '0; iv_d = '0;
      ordy_a = 1'b1; ordy_b = 1'b1; ordy_c = 1'b1; ordy_d = 1'b1;
      case (v.dut)
         0:       begin iv_a = v.iv;      ordy_a = v.ordy; end
         1:       begin iv_b = v.iv;      ordy_b = v.ordy; end
         2:       begin iv_c = v.iv[2:0]; ordy_c = v.ordy; end
         default: begin iv_d = v.iv[0:0]; ordy_d = v.ordy; data_d = v.din; end
      endcase
      #1;
      check($sformatf("v%0d_in_ready", k), 32'(obs_rdy(v.dut)), 32'(v.rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out{valid,data,sel}", k), 32'(obs_out(v.dut)),
            32'({v.vld, v.data, v.sel}));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // N=4 round-robin: rotation, backpressure, wrap/skip, idle gap, drain.
      add(0, 4'hF, 1, 0, 4'b0001, 1, 8'hA0, 0);
      add(0, 4'hF, 1, 0, 4'b0010, 1, 8'hA1, 1);
      add(0, 4'hF, 0, 0, 4'b0000, 1, 8'hA1, 1);
      add(0, 4'hF, 0, 0, 4'b0000, 1, 8'hA1, 1);
      add(0, 4'hF, 0, 0, 4'b0000, 1, 8'hA1, 1);
      add(0, 4'hF, 1, 0, 4'b0100, 1, 8'hA2, 2);
      add(0, 4'hF, 1, 0, 4'b1000, 1, 8'hA3, 3);
      add(0, 4'hF, 1, 0, 4'b0001, 1, 8'hA0, 0);
      add(0, 4'b0100, 1, 0, 4'b0100, 1, 8'hA2, 2);
      for (int i = 0; i < 5; i++) add(0, 4'b0000, 1, 0, 4'b0000, 0, 8'hA2, 2);
      add(0, 4'b0101, 1, 0, 4'b0001, 1, 8'hA0, 0);
      add(0, 4'b0101, 1, 0, 4'b0100, 1, 8'hA2, 2);
      add(0, 4'b0101, 1, 0, 4'b0001, 1, 8'hA0, 0);
      add(0, 4'b0000, 1, 0, 4'b0000, 0, 8'hA0, 0);
      // N=4 fixed priority: ch3 starves until ch1 drops.
      for (int i = 0; i < 3; i++) add(1, 4'b1010, 1, 0, 4'b0010, 1, 8'hB1, 1);
      add(1, 4'b1000, 1, 0, 4'b1000, 1, 8'hB3, 3);
      add(1, 4'b0000, 1, 0, 4'b0000, 0, 8'hB3, 3);
      // N=3 round-robin wraps 2 -> 0.
      add(2, 4'b0111, 1, 0, 4'b0001, 1, 8'hC0, 0);
      add(2, 4'b0111, 1, 0, 4'b0010, 1, 8'hC1, 1);
      add(2, 4'b0111, 1, 0, 4'b0100, 1, 8'hC2, 2);
      add(2, 4'b0111, 1, 0, 4'b0001, 1, 8'hC0, 0);
      add(2, 4'b0111, 1, 0, 4'b0010, 1, 8'hC1, 1);
      // N=1: transfer, idle, transfer, stall, transfer.
      add(3, 4'b0001, 1, 8'h5A, 4'b0001, 1, 8'h5A, 0);
      add(3, 4'b0000, 1, 8'h77, 4'b0000, 0, 8'h5A, 0);
      add(3, 4'b0001, 1, 8'h3C, 4'b0001, 1, 8'h3C, 0);
      add(3, 4'b0001, 0, 8'h99, 4'b0000, 1, 8'h3C, 0);
      add(3, 4'b0001, 1, 8'h99, 4'b0001, 1, 8'h99, 0);

      // Reset state, with requests present to confirm in_ready is held low.
      iv_a = 4'hF;
      #3;
      check("reset_in_ready", 32'(rdy_a), 32'h0);
      check("reset_out", 32'({ov_a, od_a, os_a}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      iv_a = '0;
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

      // Asynchronous reset while a word is stalled in the output register.
      @(negedge clk);
      iv_a = 4'hF; ordy_a = 1'b1;
      iv_b = '0; iv_c = '0; iv_d = '0;
      @(posedge clk);
      #1;
      check("pre_rst_load", 32'({ov_a, od_a, os_a}), 32'({1'b1, 8'hA1, 2'd1}));
      @(negedge clk);
      ordy_a = 1'b0;
      @(posedge clk);
      #2;
      check("pre_rst_stall", 32'({ov_a, od_a, os_a, rdy_a}), 32'({1'b1, 8'hA1, 2'd1, 4'b0000}));
      rst_n = 1'b0;
      #1;
      check("async_rst_out", 32'({ov_a, od_a, os_a}), 32'h0);
      check("async_rst_in_ready", 32'(rdy_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ordy_a = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(rdy_a), 32'(4'b0001));
      @(posedge clk);
      #1;
      check("post_rst_first", 32'({ov_a, od_a, os_a}), 32'({1'b1, 8'hA0, 2'd0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
